hdc_assoc_search: RTL
=====================

Name: hdc_assoc_search

Overview:
- Associative-search stage directly downstream of the class hypervector generator `class_vec_gen`.
- Buffers one encoded query hypervector, delivered as N_FRAMES frames of FRAME_W bits.
- Walks every (class, frame) pair by driving `class_vec_gen`'s frame_id/frame_index, and accumulates the Hamming distance (popcount of XOR) per class.
- Reports the class with minimum distance plus that distance over a valid/ready handshake.

Parameters:
- FRAME_W, 64, bits per hypervector frame.
- N_FRAMES, 3, frames per hypervector.
- N_CLASSES, 8, number of classes.
- CLASS_W, 3, width of frame_id / class index; must satisfy 2^CLASS_W >= N_CLASSES.
- FIDX_W, 2, width of frame_index; must satisfy 2^FIDX_W >= N_FRAMES.
- DIST_W, 8, distance width; must be >= clog2(FRAME_W*N_FRAMES+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- q_valid  in  1  query frame valid.
- q_ready  out  1  block accepts a query frame.
- q_frame  in  FRAME_W  query frame; frames arrive in order 0..N_FRAMES-1.
- frame_id  out  CLASS_W  class select to `class_vec_gen`.
- frame_index  out  FIDX_W  frame select to `class_vec_gen`.
- class_vec_in  in  FRAME_W  `class_vec_gen` class_vec_out; combinational, valid in the same cycle.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_class  out  CLASS_W  winning class index.
- res_dist  out  DIST_W  winning Hamming distance.
- busy  out  1  high in SEARCH or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=LOAD; all counters, frame_id, frame_index, acc, best_dist, res_class and res_dist are 0; q_ready=1; res_valid=0; busy=0. The query buffer is not reset.
- LOAD:
  - q_ready=1.
  - On q_valid&&q_ready, qbuf[ld_cnt] <= q_frame and ld_cnt increments.
  - When the frame with ld_cnt==N_FRAMES-1 is accepted: ld_cnt<=0, frame_id<=0, frame_index<=0, acc<=0, go to SEARCH.
  - Frame count alone delimits queries; there is no last flag.
- SEARCH (q_ready=0):
  - One (class, frame) pair per cycle; frame_id/frame_index are registered counters.
  - Each cycle: d = popcount(qbuf[frame_index] ^ class_vec_in), zero-extended to DIST_W.
  - If frame_index < N_FRAMES-1: acc <= acc + d; frame_index increments.
  - If frame_index == N_FRAMES-1:
    - total = acc + d.
    - If frame_id==0, or total < best_dist (strict), then best_dist <= total and best_class <= frame_id.
    - Then acc<=0 and frame_index<=0.
    - If frame_id == N_CLASSES-1: go to DONE. Otherwise frame_id increments.
  - Ties keep the lowest class index.
  - No overflow is possible given the DIST_W constraint.
- DONE:
  - res_valid=1; res_class=best_class; res_dist=best_dist. Outputs are held stable while res_ready=0.
  - On res_valid&&res_ready: res_valid<=0, go to LOAD. q_ready rises the next cycle; there is no same-cycle query accept.
- frame_id/frame_index in LOAD and DONE: held at 0.
- Latency: first frame accept to res_valid = N_FRAMES + N_CLASSES*N_FRAMES cycles (27 at defaults), with q_valid held high.
  - Throughput: one query per 28 cycles minimum, including the DONE handshake cycle.
- q_valid stalls during LOAD simply pause ld_cnt; already accepted frames are retained.
- Reset mid-operation (any state): returns immediately to the reset values; any partial query or result is discarded.
- Behaviour when q_frame changes while q_ready=0: don't care (input ignored).

Test Plan:
- Bench drives `class_vec_gen` with production contents; query = 3 all-zero frames → res_valid after 27 cycles, res_class=1, res_dist=1. Class 4 also has distance 1; the tie resolves to the lower index.
- Stub ROM: all classes all-zero except class 5 = {64'hFFFF_0000_FFFF_0000 ×3}; query equal to class 5 → res_class=5, res_dist=0.
- Stub ROM all zeros; query all ones (3×64'hFFFF_FFFF_FFFF_FFFF) → res_class=0, res_dist=192 (8'hC0), with no overflow.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid → res_valid, res_class and res_dist stable, q_ready=0. Release → q_ready=1 one cycle later; a second query loads and produces its correct result.
- q_valid toggling 1,0,1,0,1 during LOAD → exactly 3 frames captured in order; SEARCH starts the cycle after the third accept.
- Assert rst_n=0 when frame_id=4, frame_index=1 → asynchronously res_valid=0, q_ready=1, frame_id=0, frame_index=0. A fresh query after release yields the correct result with no carry-over of the old best_dist.

Source files
------------

// File: rtl/hdc_assoc_search_if.sv
// hdc_assoc_search_if: query input, class ROM select and result output signals of the search stage
interface hdc_assoc_search_if #(
  parameter int FRAME_W = 64,
  parameter int CLASS_W = 3,
  parameter int FIDX_W  = 2,
  parameter int DIST_W  = 8
);
  logic               q_valid;
  logic               q_ready;
  logic [FRAME_W-1:0] q_frame;
  logic [CLASS_W-1:0] frame_id;
  logic [FIDX_W-1:0]  frame_index;
  logic [FRAME_W-1:0] class_vec_in;
  logic               res_valid;
  logic               res_ready;
  logic [CLASS_W-1:0] res_class;
  logic [DIST_W-1:0]  res_dist;
  logic               busy;
  modport slave (
    input  q_valid, q_frame, class_vec_in, res_ready,
    output q_ready, frame_id, frame_index, res_valid, res_class, res_dist, busy
  );
  modport master (
    output q_valid, q_frame, class_vec_in, res_ready,
    input  q_ready, frame_id, frame_index, res_valid, res_class, res_dist, busy
  );
endinterface

// File: rtl/hdc_assoc_search.sv
// hdc_assoc_search: buffers one query hypervector and finds the class with minimum Hamming distance
module hdc_assoc_search #(
  parameter int FRAME_W   = 64,
  parameter int N_FRAMES  = 3,
  parameter int N_CLASSES = 8,
  parameter int CLASS_W   = 3,
  parameter int FIDX_W    = 2,
  parameter int DIST_W    = 8
) (
  input logic clk,
  input logic rst_n,
  hdc_assoc_search_if.slave bus
);
  typedef enum logic [1:0] {LOAD, SEARCH, DONE} state_t;
  state_t r_state, w_state_n;
  logic [FRAME_W-1:0] r_qbuf [N_FRAMES];
  logic [FIDX_W-1:0]  r_ld, w_ld_n, r_fidx, w_fidx_n;
  logic [CLASS_W-1:0] r_fid, w_fid_n, r_best_class, w_best_class_n;
  logic [DIST_W-1:0]  r_acc, w_acc_n, r_best_dist, w_best_dist_n, w_d, w_total;
  logic               w_q_acc, w_last_f, w_last_c, w_last_ld;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= LOAD;
      r_ld         <= '0;
      r_fid        <= '0;
      r_fidx       <= '0;
      r_acc        <= '0;
      r_best_dist  <= '0;
      r_best_class <= '0;
    end else begin
      r_state      <= w_state_n;
      r_ld         <= w_ld_n;
      r_fid        <= w_fid_n;
      r_fidx       <= w_fidx_n;
      r_acc        <= w_acc_n;
      r_best_dist  <= w_best_dist_n;
      r_best_class <= w_best_class_n;
    end

  // query buffer carries no reset; it is always fully rewritten before use
  always_ff @(posedge clk)
    if (w_q_acc) r_qbuf[r_ld] <= bus.q_frame;

  always_comb begin
    w_q_acc        = bus.q_valid && r_state == LOAD;
    w_d            = DIST_W'($countones(r_qbuf[r_fidx] ^ bus.class_vec_in));
    w_total        = r_acc + w_d;
    w_last_f       = r_fidx == FIDX_W'(N_FRAMES - 1);
    w_last_c       = r_fid == CLASS_W'(N_CLASSES - 1);
    w_last_ld      = r_ld == FIDX_W'(N_FRAMES - 1);
    w_state_n      = r_state;
    w_ld_n         = r_ld;
    w_fid_n        = r_fid;
    w_fidx_n       = r_fidx;
    w_acc_n        = r_acc;
    w_best_dist_n  = r_best_dist;
    w_best_class_n = r_best_class;
    case (r_state)
      LOAD:
        if (w_q_acc) begin
          w_ld_n = w_last_ld ? '0 : r_ld + 1'b1;
          if (w_last_ld) begin
            w_state_n = SEARCH;
            w_fid_n   = '0;
            w_fidx_n  = '0;
            w_acc_n   = '0;
          end
        end
      SEARCH:
        if (!w_last_f) begin
          w_acc_n  = w_total;
          w_fidx_n = r_fidx + 1'b1;
        end else begin
          // strict compare keeps the lowest class index on ties
          if (r_fid == '0 || w_total < r_best_dist) begin
            w_best_dist_n  = w_total;
            w_best_class_n = r_fid;
          end
          w_acc_n   = '0;
          w_fidx_n  = '0;
          w_fid_n   = w_last_c ? '0 : r_fid + 1'b1;
          w_state_n = w_last_c ? DONE : SEARCH;
        end
      DONE:
        if (bus.res_ready) w_state_n = LOAD;
      default: w_state_n = LOAD;
    endcase
  end

  assign bus.q_ready     = r_state == LOAD;
  assign bus.res_valid   = r_state == DONE;
  assign bus.busy        = r_state != LOAD;
  assign bus.frame_id    = r_fid;
  assign bus.frame_index = r_fidx;
  assign bus.res_class   = r_best_class;
  assign bus.res_dist    = r_best_dist;
endmodule
